alu_fpga_seq: RTL and testbench
===============================

// Module: alu_fpga_seq
// PURPOSE
//  Clocked board-level test harness for the alu block, replacing the latch-based
//  switch/key wrapper. Operands and opcode are entered in sequence from SW under a
//  debounced KEY-driven FSM. The result is registered, and a selected page is shown
//  on a parametrised bank of 7-segment digits. Result chaining (A <= result) is supported.
// PARAMETERS
//  DATA_W    32  ALU operand/result width; must be a multiple of 4
//  DIGITS    8   number of 7-seg digits driven; must be >= 1
//  DEBOUNCE  16  cycles a synchronised key level must hold stable to be accepted (>=2)
// PORTS
//  CLK    in   1          system clock
//  RST    in   1          synchronous active-high reset
//  SW     in   18         SW[15:0] value; SW[16]=1 zero-extend, 0 sign-extend
//  KEY    in   4          active-low pushbuttons: 0 next/load, 1 chain, 2 page, 3 clear
//  HEX    out  DIGITS*7   HEX[7i+6:7i] = digit i (nibble i), active-low segments
//  FLAGS  out  3          {oveF,zerF,negF} registered at EXEC
//  STATE  out  3          one-hot {SHOW,LOAD_B,LOAD_A}; LOAD_OP/EXEC shown as 3'b000
// BEHAVIOUR
//  Reset: regA=regB=res=0, op=0, FLAGS=0, page=RESULT, state=LOAD_A,
//    debouncers at released level with no events; HEX shows the live extended SW.
//  Key path: 2-flop sync -> stable counter -> debounced level; a press event is a
//    1-cycle pulse on the debounced 1->0 edge, no earlier than 2+DEBOUNCE cycles after
//    the pin changes. Holding a key yields one event. Bounces shorter than DEBOUNCE
//    are ignored.
//  ext = SW[16] ? zero-extend(SW[15:0]) : sign-extend(SW[15:0]) to DATA_W.
//  Event priority in one cycle: clear > next > chain > page. Lower events are dropped.
//  FSM:
//    LOAD_A  --next--> regA<=ext, LOAD_B
//    LOAD_B  --next--> regB<=ext, LOAD_OP
//    LOAD_OP --next--> op<=SW[3:0], EXEC
//    EXEC    (1 cycle, unconditional): res<=outPort, FLAGS<={oveF,zerF,negF}, SHOW
//    SHOW    --next--> LOAD_A; regs and res held
//            --chain--> regA<=res, LOAD_B
//            --page--> RESULT->A->B->RESULT
//    clear (any state): same effect as RST, but debouncer state is kept.
//  The alu instance is driven combinationally from regA/regB/op.
//    Result latency: EXEC is the cycle after the op-load event; res is valid the next cycle.
//  Display:
//    In LOAD_A/LOAD_B/LOAD_OP, HEX shows ext live.
//    In EXEC/SHOW, HEX shows the page value (res, regA or regB).
//    Digit i shows nibble i, hex font 0-F.
//    Digits with i >= DATA_W/4 are blank (7'h7F). Nibbles beyond DIGITS are not shown.
//  page persists across LOAD states and resets to RESULT only on reset or clear.
//  All outputs are registered or decoded from registered state only; no combinational
//    path from SW/KEY to HEX except the live ext value in LOAD states.
// TESTING (DEBOUNCE=4, DATA_W=32, DIGITS=8)
//  Reset, then hold: STATE=3'b001, FLAGS=0.
//    SW=18'h00012 -> HEX digits = 0000_0012.
//  Load A=5, B=3, op=ALU_ADD via three KEY0 presses
//    -> res=32'h8, FLAGS=3'b000, STATE=3'b100.
//    Event-to-SHOW count matches the latency rule.
//  Load A=18'h08000 (sign-extend), B=1, op=ALU_SUB
//    -> A shown as FFFF8000; res=FFFF7FFF, negF=1.
//    Repeat with SW[16]=1 -> res=00007FFF.
//  Load A=32'h7FFF_FFFF-equivalent via chain: res=7FFF, KEY1, B=7FFF..., ADD
//    -> regA took the old res; oveF set correctly.
//  KEY0 bounce of 2-cycle pulses -> no event.
//    KEY0 and KEY3 pressed on the same cycle -> clear wins, state=LOAD_A, regs 0.
//  In SHOW, three KEY2 presses -> HEX cycles regA, regB, res.
//    DIGITS=10 variant: digits 8-9 = 7'h7F.
//    RST asserted mid-debounce -> clean reset, no spurious event afterwards.

Source files
------------

// File: rtl/alu_fpga_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_fpga_seq
//  Description : Clocked board-level harness around a combinational ALU.
//                Operand A, operand B and the opcode are entered one after the
//                other from SW, each captured by a debounced KEY0 press. The
//                result and flags are registered, and a selectable page
//                (result, A or B) is shown on a bank of 7-segment digits.
//                Result chaining (A <= result) is available from SHOW.
//  Ports       : CLK    system clock
//                RST    synchronous active-high reset
//                SW     [15:0] value, [16] 1 = zero-extend / 0 = sign-extend
//                KEY    active-low buttons: 0 next/load, 1 chain, 2 page,
//                       3 clear
//                HEX    digit i on HEX[7i+6:7i], shows nibble i, active-low
//                FLAGS  {overflow, zero, negative}, captured at EXEC
//                STATE  one-hot {SHOW, LOAD_B, LOAD_A}; 000 in LOAD_OP/EXEC
//  Opcodes     : 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU,
//                8 SLL, 9 SRL, 10 SRA, 11-15 give zero. Overflow only for
//                ADD/SUB (signed).
//  Revision    : 1.0  initial release
// ============================================================================
module alu_fpga_seq #(
    parameter int DATA_W   = 32,
    parameter int DIGITS   = 8,
    parameter int DEBOUNCE = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [17:0]           SW,
    input  logic [3:0]            KEY,
    output logic [DIGITS*7-1:0]   HEX,
    output logic [2:0]            FLAGS,
    output logic [2:0]            STATE
);

    localparam int c_NIBBLES = DATA_W / 4;
    localparam int c_CNT_W   = $clog2(DEBOUNCE + 1);
    localparam int c_SH_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [2:0] c_LOAD_A  = 3'd0;
    localparam logic [2:0] c_LOAD_B  = 3'd1;
    localparam logic [2:0] c_LOAD_OP = 3'd2;
    localparam logic [2:0] c_EXEC    = 3'd3;
    localparam logic [2:0] c_SHOW    = 3'd4;

    localparam logic [1:0] c_PG_RES = 2'd0;
    localparam logic [1:0] c_PG_A   = 2'd1;
    localparam logic [1:0] c_PG_B   = 2'd2;

    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_SUB  = 4'd1;
    localparam logic [3:0] c_OP_AND  = 4'd2;
    localparam logic [3:0] c_OP_OR   = 4'd3;
    localparam logic [3:0] c_OP_XOR  = 4'd4;
    localparam logic [3:0] c_OP_NOR  = 4'd5;
    localparam logic [3:0] c_OP_SLT  = 4'd6;
    localparam logic [3:0] c_OP_SLTU = 4'd7;
    localparam logic [3:0] c_OP_SLL  = 4'd8;
    localparam logic [3:0] c_OP_SRL  = 4'd9;
    localparam logic [3:0] c_OP_SRA  = 4'd10;

    // ------------------------------------------------------------------------
    // Key debouncers: 2-flop synchroniser, stability counter, debounced level.
    // Reset only by RST so that a clear press does not retrigger itself.
    // ------------------------------------------------------------------------
    logic [3:0] w_evt;

    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_key
            logic               r_s1;
            logic               r_s2;
            logic               r_lvl;
            logic               r_evt;
            logic [c_CNT_W-1:0] r_cnt;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_s1  <= 1'b1;
                    r_s2  <= 1'b1;
                    r_lvl <= 1'b1;
                    r_evt <= 1'b0;
                    r_cnt <= '0;
                end else begin
                    r_s1  <= KEY[k];
                    r_s2  <= r_s1;
                    r_evt <= 1'b0;
                    if (r_s2 == r_lvl) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_CNT_W'(DEBOUNCE - 1)) begin
                        // New level has held long enough; a press is a 1->0 move.
                        r_lvl <= r_s2;
                        r_cnt <= '0;
                        r_evt <= r_lvl;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_evt[k] = r_evt;
        end
    endgenerate

    logic w_ev_next, w_ev_chain, w_ev_page, w_ev_clear;
    assign w_ev_next  = w_evt[0];
    assign w_ev_chain = w_evt[1];
    assign w_ev_page  = w_evt[2];
    assign w_ev_clear = w_evt[3];

    // ------------------------------------------------------------------------
    // Operand extension from the switches
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] w_ext;
    logic              w_unused;

    assign w_ext    = SW[16] ? DATA_W'(SW[15:0]) : DATA_W'($signed(SW[15:0]));
    assign w_unused = SW[17];

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [2:0]        r_state, w_state_nxt;
    logic [DATA_W-1:0] r_a, w_a_nxt;
    logic [DATA_W-1:0] r_b, w_b_nxt;
    logic [DATA_W-1:0] r_res, w_res_nxt;
    logic [3:0]        r_op, w_op_nxt;
    logic [2:0]        r_flags, w_flags_nxt;
    logic [1:0]        r_page, w_page_nxt;

    // ------------------------------------------------------------------------
    // ALU, driven combinationally from the operand registers
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] w_sum, w_diff, w_alu_res;
    logic [c_SH_W-1:0] w_shamt;
    logic              w_alu_ov;

    assign w_sum   = r_a + r_b;
    assign w_diff  = r_a - r_b;
    assign w_shamt = r_b[c_SH_W-1:0];

    always_comb begin
        w_alu_res = '0;
        w_alu_ov  = 1'b0;
        case (r_op)
            c_OP_ADD: begin
                w_alu_res = w_sum;
                // Same-sign operands producing a different-sign sum.
                w_alu_ov  = (r_a[DATA_W-1] == r_b[DATA_W-1]) &&
                            (w_sum[DATA_W-1] != r_a[DATA_W-1]);
            end
            c_OP_SUB: begin
                w_alu_res = w_diff;
                w_alu_ov  = (r_a[DATA_W-1] != r_b[DATA_W-1]) &&
                            (w_diff[DATA_W-1] != r_a[DATA_W-1]);
            end
            c_OP_AND:  w_alu_res = r_a & r_b;
            c_OP_OR:   w_alu_res = r_a | r_b;
            c_OP_XOR:  w_alu_res = r_a ^ r_b;
            c_OP_NOR:  w_alu_res = ~(r_a | r_b);
            c_OP_SLT:  w_alu_res = DATA_W'($signed(r_a) < $signed(r_b));
            c_OP_SLTU: w_alu_res = DATA_W'(r_a < r_b);
            c_OP_SLL:  w_alu_res = r_a << w_shamt;
            c_OP_SRL:  w_alu_res = r_a >> w_shamt;
            c_OP_SRA:  w_alu_res = $signed(r_a) >>> w_shamt;
            default:   w_alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Sequencer: next-state and register updates
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_res_nxt   = r_res;
        w_op_nxt    = r_op;
        w_flags_nxt = r_flags;
        w_page_nxt  = r_page;

        if (w_ev_clear) begin
            w_state_nxt = c_LOAD_A;
            w_a_nxt     = '0;
            w_b_nxt     = '0;
            w_res_nxt   = '0;
            w_op_nxt    = '0;
            w_flags_nxt = '0;
            w_page_nxt  = c_PG_RES;
        end else begin
            case (r_state)
                c_LOAD_A: begin
                    if (w_ev_next) begin
                        w_a_nxt     = w_ext;
                        w_state_nxt = c_LOAD_B;
                    end
                end
                c_LOAD_B: begin
                    if (w_ev_next) begin
                        w_b_nxt     = w_ext;
                        w_state_nxt = c_LOAD_OP;
                    end
                end
                c_LOAD_OP: begin
                    if (w_ev_next) begin
                        w_op_nxt    = SW[3:0];
                        w_state_nxt = c_EXEC;
                    end
                end
                c_EXEC: begin
                    w_res_nxt   = w_alu_res;
                    w_flags_nxt = {w_alu_ov, (w_alu_res == '0), w_alu_res[DATA_W-1]};
                    w_state_nxt = c_SHOW;
                end
                c_SHOW: begin
                    if (w_ev_next) begin
                        w_state_nxt = c_LOAD_A;
                    end else if (w_ev_chain) begin
                        w_a_nxt     = r_res;
                        w_state_nxt = c_LOAD_B;
                    end else if (w_ev_page) begin
                        w_page_nxt  = (r_page == c_PG_B) ? c_PG_RES : r_page + 2'd1;
                    end
                end
                default: w_state_nxt = c_LOAD_A;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_LOAD_A;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_op    <= '0;
            r_flags <= '0;
            r_page  <= c_PG_RES;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_res   <= w_res_nxt;
            r_op    <= w_op_nxt;
            r_flags <= w_flags_nxt;
            r_page  <= w_page_nxt;
        end
    end

    assign FLAGS = r_flags;
    assign STATE = {(r_state == c_SHOW), (r_state == c_LOAD_B), (r_state == c_LOAD_A)};

    // ------------------------------------------------------------------------
    // Display: live switch value while loading, selected page otherwise
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] w_disp;

    always_comb begin
        w_disp = w_ext;
        if ((r_state == c_EXEC) || (r_state == c_SHOW)) begin
            case (r_page)
                c_PG_A:  w_disp = r_a;
                c_PG_B:  w_disp = r_b;
                default: w_disp = r_res;
            endcase
        end
    end

    function automatic logic [6:0] f_font(input logic [3:0] n);
        case (n)
            4'h0: f_font = 7'h40;
            4'h1: f_font = 7'h79;
            4'h2: f_font = 7'h24;
            4'h3: f_font = 7'h30;
            4'h4: f_font = 7'h19;
            4'h5: f_font = 7'h12;
            4'h6: f_font = 7'h02;
            4'h7: f_font = 7'h78;
            4'h8: f_font = 7'h00;
            4'h9: f_font = 7'h10;
            4'hA: f_font = 7'h08;
            4'hB: f_font = 7'h03;
            4'hC: f_font = 7'h46;
            4'hD: f_font = 7'h21;
            4'hE: f_font = 7'h06;
            default: f_font = 7'h0E;
        endcase
    endfunction

    genvar i;
    generate
        for (i = 0; i < DIGITS; i++) begin : g_digit
            if (i < c_NIBBLES) begin : g_nib
                assign HEX[7*i +: 7] = f_font(w_disp[4*i +: 4]);
            end else begin : g_blank
                assign HEX[7*i +: 7] = 7'h7F;
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_alu_fpga_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_fpga_seq
//  Description : Self-checking bench for alu_fpga_seq (DATA_W=32, DIGITS=10,
//                DEBOUNCE=4). Stimulus pushes expected results into a
//                scoreboard queue; a monitor pops and compares each time the
//                design enters SHOW.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_fpga_seq;

    localparam int DW = 32;
    localparam int DG = 10;
    localparam int DB = 4;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_SLL = 4'd8;

    localparam logic [6:0] FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic              clk = 1'b0;
    logic              rst;
    logic [17:0]       sw;
    logic [3:0]        key;
    logic [DG*7-1:0]   hex;
    logic [2:0]        flags;
    logic [2:0]        state;

    always #5 clk = ~clk;

    alu_fpga_seq #(.DATA_W(DW), .DIGITS(DG), .DEBOUNCE(DB)) dut (
        .CLK   (clk),
        .RST   (rst),
        .SW    (sw),
        .KEY   (key),
        .HEX   (hex),
        .FLAGS (flags),
        .STATE (state)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] disp;
        logic [2:0]  flags;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state
    logic [31:0] m_a, m_b, m_res;
    logic [2:0]  m_flags;
    int          m_page;
    bit          m_show;

    function automatic logic [69:0] hex_of(input logic [31:0] v);
        logic [69:0] h;
        h = '0;
        for (int i = 0; i < DG; i++) begin
            if (i < 8) h[7*i +: 7] = FONT[v[4*i +: 4]];
            else       h[7*i +: 7] = 7'h7F;
        end
        return h;
    endfunction

    function automatic logic [31:0] ext_of(input logic [17:0] s);
        return s[16] ? {16'h0000, s[15:0]} : {{16{s[15]}}, s[15:0]};
    endfunction

    // Returns {flags, result}
    function automatic logic [34:0] alu_ref(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, s, lim;
        logic [31:0] r;
        logic ov;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        lim = 64'sd2147483648;
        ov  = 1'b0;
        r   = '0;
        case (op)
            4'd0: begin s = sa + sb; r = 32'(s); ov = (s >= lim) || (s < -lim); end
            4'd1: begin s = sa - sb; r = 32'(s); ov = (s >= lim) || (s < -lim); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~(a | b);
            4'd6: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd7: r = (a < b) ? 32'd1 : 32'd0;
            4'd8: r = a << b[4:0];
            4'd9: r = a >> b[4:0];
            4'd10: r = 32'(sa >>> b[4:0]);
            default: r = '0;
        endcase
        return {ov, (r == 32'd0), r[31], r};
    endfunction

    function automatic logic [31:0] cur_disp();
        if (m_page == 1) return m_a;
        if (m_page == 2) return m_b;
        return m_res;
    endfunction

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_a = '0; m_b = '0; m_res = '0; m_flags = '0; m_page = 0; m_show = 0;
    endtask

    // ------------------------------------------------------------------------
    // Monitor: one scoreboard entry per entry into SHOW
    // ------------------------------------------------------------------------
    logic [2:0] prev_state = 3'b001;
    exp_t       mon_e;

    always @(negedge clk) begin
        if (!rst && state == 3'b100 && prev_state != 3'b100) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_show: got SHOW with empty scoreboard");
            end else begin
                mon_e = sb_q.pop_front();
                check("show_hex", hex, hex_of(mon_e.disp));
                check("show_flags", 70'(flags), 70'(mon_e.flags));
            end
        end
        prev_state = state;
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic press(input logic [3:0] mask);
        @(negedge clk);
        key = ~mask;
        repeat (DB + 4) @(negedge clk);
        key = 4'hF;
        repeat (DB + 4) @(negedge clk);
    endtask

    task automatic leave_show();
        if (m_show) begin
            press(4'b0001);
            m_show = 0;
        end
    endtask

    task automatic load_a(input logic [17:0] s);
        sw = s;
        press(4'b0001);
        m_a = ext_of(s);
    endtask

    task automatic load_b(input logic [17:0] s);
        sw = s;
        press(4'b0001);
        m_b = ext_of(s);
    endtask

    task automatic do_op(input logic [3:0] op);
        logic [34:0] r;
        exp_t e;
        int n;
        sw = {14'h0, op};
        r = alu_ref(op, m_a, m_b);
        m_res   = r[31:0];
        m_flags = r[34:32];
        e.disp  = cur_disp();
        e.flags = m_flags;
        sb_q.push_back(e);
        @(negedge clk);
        key[0] = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (state !== 3'b100 && n < 40);
        check("op_to_show_latency", 70'(n), 70'(DB + 4));
        @(negedge clk);
        key = 4'hF;
        repeat (DB + 4) @(negedge clk);
        m_show = 1;
    endtask

    task automatic run(input logic [17:0] sa, input logic [17:0] sb, input logic [3:0] op);
        leave_show();
        load_a(sa);
        load_b(sb);
        do_op(op);
    endtask

    task automatic chain(input logic [17:0] sb, input logic [3:0] op);
        press(4'b0010);
        m_a = m_res;
        m_show = 0;
        load_b(sb);
        do_op(op);
    endtask

    task automatic page_press();
        press(4'b0100);
        m_page = (m_page + 1) % 3;
        check("page_hex", hex, hex_of(cur_disp()));
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        logic [17:0] rs;
        rst = 1'b1;
        sw  = '0;
        key = 4'hF;
        model_reset();
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_state", 70'(state), 70'(3'b001));
        check("reset_flags", 70'(flags), 70'(3'b000));

        sw = 18'h00012;
        #1;
        check("live_hex_12", hex, hex_of(32'h0000_0012));

        // Basic add
        run(18'h00005, 18'h00003, OP_ADD);
        check("add_hex", hex, hex_of(32'h0000_0008));
        check("add_flags", 70'(flags), 70'(3'b000));
        check("add_state", 70'(state), 70'(3'b100));

        // Sign-extended subtract, then cycle the pages
        run(18'h08000, 18'h00001, OP_SUB);
        page_press();
        check("page_a_hex", hex, hex_of(32'hFFFF_8000));
        page_press();
        page_press();
        check("sub_sext_hex", hex, hex_of(32'hFFFF_7FFF));
        check("sub_sext_neg", 70'(flags[0]), 70'(1'b1));

        // Zero-extended variant
        run(18'h18000, 18'h10001, OP_SUB);
        check("sub_zext_hex", hex, hex_of(32'h0000_7FFF));

        // Chaining into signed overflow
        run(18'h00001, 18'h0001F, OP_SLL);
        chain(18'h0FFFF, OP_ADD);
        check("chain_ovf_hex", hex, hex_of(32'h7FFF_FFFF));
        check("chain_ovf_flags", 70'(flags), 70'(3'b100));
        chain(18'h00001, OP_ADD);
        check("chain_ovf2_flags", 70'(flags), 70'(3'b101));

        // Randomised transactions
        for (int it = 0; it < 24; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    chain(18'($urandom), 4'($urandom_range(0, 15)));
                end
                1: begin
                    page_press();
                    run(18'($urandom), 18'($urandom), 4'($urandom_range(0, 15)));
                end
                default: begin
                    leave_show();
                    load_a(18'($urandom));
                    rs = 18'($urandom);
                    sw = rs;
                    #1;
                    check("live_hex_rand", hex, hex_of(ext_of(rs)));
                    load_b(rs);
                    do_op(4'($urandom_range(0, 15)));
                end
            endcase
        end

        // Known non-zero flags and a non-result page before the clear
        run(18'h00000, 18'h00001, OP_SUB);
        if (m_page == 0) page_press();

        // Bounces shorter than the debounce window must not register
        leave_show();
        check("state_load_a", 70'(state), 70'(3'b001));
        for (int b = 0; b < 4; b++) begin
            @(negedge clk); key[0] = 1'b0;
            @(negedge clk);
            @(negedge clk); key[0] = 1'b1;
            @(negedge clk);
        end
        repeat (20) @(negedge clk);
        check("bounce_ignored", 70'(state), 70'(3'b001));

        // Next and clear together: clear wins
        load_a(18'($urandom));
        check("state_load_b", 70'(state), 70'(3'b010));
        press(4'b1001);
        model_reset();
        check("clear_state", 70'(state), 70'(3'b001));
        check("clear_flags", 70'(flags), 70'(3'b000));
        run(18'h00002, 18'h00002, OP_SUB);
        check("after_clear_hex", hex, hex_of(32'h0000_0000));

        // Reset in the middle of a debounce
        leave_show();
        load_a(18'h00007);
        @(negedge clk);
        key[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        key = 4'hF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (20) @(negedge clk);
        check("rst_mid_state", 70'(state), 70'(3'b001));
        check("rst_mid_flags", 70'(flags), 70'(3'b000));

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 70'(sb_q.size()), 70'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
